// File: rtl/product_acc_pkg.sv
// product_acc_pkg: shared state type and sizing constants for product_accumulator
package product_acc_pkg;
  typedef enum logic {ACCUM, DUMP} state_t;
  localparam int ACC_W_DEF = 16;
  localparam int BYTES = ACC_W_DEF / 8;
endpackage

// File: rtl/sat_adder.sv
// sat_adder: ACC_W-bit plus 8-bit unsigned add that clamps to all-ones on carry-out
module sat_adder #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [7:0]       b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W:0] full;
  assign full = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
  assign ovf  = full[ACC_W];
  assign sum  = ovf ? '1 : full[ACC_W-1:0];
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: saturating sum of 8-bit products with LSB-first serial byte readout
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W         = ACC_W_DEF,
  parameter bit CLEAR_ON_DUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_product,
  output logic       in_ready,
  input  logic       acc_clear,
  input  logic       dump,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       overflow,
  output logic [7:0] count
);
  localparam int NB = ACC_W / 8;
  localparam int IW = $clog2(NB);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [ACC_W-1:0] acc, base, sum;
  logic [NB-1:0][7:0] snap;
  logic add_ovf, accept, clr, hs;
  assign accept    = in_valid && state == ACCUM;
  assign clr       = acc_clear && state == ACCUM;
  assign hs        = out_valid && out_ready;
  // a same-cycle clear restarts the sum from the incoming product
  assign base      = clr ? '0 : acc;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DUMP;
  assign out_last  = state == DUMP && idx == IW'(NB - 1);
  assign out_data  = snap[idx];
  sat_adder #(.ACC_W(ACC_W)) u_add (
    .a   (base),
    .b   (in_product),
    .sum (sum),
    .ovf (add_ovf)
  );
  always_comb
    state_nx = state == ACCUM ? (dump ? DUMP : ACCUM) : (hs && out_last ? ACCUM : DUMP);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      idx      <= '0;
      acc      <= '0;
      snap     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ACCUM) begin
        if (accept) begin
          acc      <= sum;
          count    <= clr ? 8'd1 : count + {7'd0, count != 8'hFF};
          overflow <= clr ? add_ovf : overflow | add_ovf;
        end else if (clr) begin
          acc      <= '0;
          count    <= '0;
          overflow <= 1'b0;
        end
        if (dump) begin
          snap <= accept ? sum : base;
          idx  <= '0;
        end
      end else if (hs) begin
        idx <= out_last ? '0 : idx + 1'b1;
        if (out_last && CLEAR_ON_DUMP) begin
          acc      <= '0;
          count    <= '0;
          overflow <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: ACC_W, 16, accumulator width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter: CLEAR_ON_DUMP, 1, when 1 the accumulator, count and overflow SHALL be cleared on completion of a dump.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  in  1  an 8-bit unsigned product from the upstream 4x4 array multiplier is present.
REQ-006 Port: in_product  in  8  unsigned product value.
REQ-007 Port: in_ready  out  1  block can accept a product this cycle.
REQ-008 Port: acc_clear  in  1  synchronous clear of accumulator, count and overflow.
REQ-009 Port: dump  in  1  request serial byte readout of the accumulator.
REQ-010 Port: out_valid  out  1  out_data holds a valid readout byte.
REQ-011 Port: out_data  out  8  readout byte, least significant byte first.
REQ-012 Port: out_last  out  1  marks the most significant (final) byte.
REQ-013 Port: out_ready  in  1  downstream accepts the byte.
REQ-014 Port: overflow  out  1  sticky saturation flag.
REQ-015 Port: count  out  8  number of accepted products since the last clear; saturates at 255.

Function
REQ-016 FSM states: ACCUM and DUMP; the byte index SHALL be a counter from 0 to ACC_W/8-1.
REQ-017 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in DUMP, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-018 Accept means in_valid and in_ready are both 1 in the same cycle; acc SHALL become acc + in_product (zero-extended) on the next edge; latency is one cycle.
REQ-019 If the sum exceeds 2^ACC_W-1, acc SHALL hold 2^ACC_W-1 and overflow SHALL be set; overflow SHALL remain set until it is cleared.
REQ-020 count SHALL increment on each accept and SHALL hold at 255.
REQ-021 acc_clear in ACCUM together with an accept: acc SHALL become in_product, count SHALL become 1, overflow SHALL become 0.
REQ-022 acc_clear while in DUMP SHALL be ignored.
REQ-023 dump in ACCUM SHALL move the FSM to DUMP with byte index 0 and snapshot acc into a readout register; an accept in the same cycle SHALL be included in the snapshot.
REQ-024 dump while in DUMP SHALL be ignored.
REQ-025 In DUMP, out_data SHALL be snapshot byte [index]; out_last SHALL be 1 only at index ACC_W/8-1.
REQ-026 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 A handshake (out_valid and out_ready) SHALL advance the index; a handshake with out_last=1 SHALL return the FSM to ACCUM and SHALL apply CLEAR_ON_DUMP.
REQ-028 in_valid while in DUMP SHALL NOT be accepted, and the product SHALL NOT be lost; upstream holds it.

Reset
REQ-029 While rst_n=0: acc=0, snapshot=0, count=0, overflow=0, state=ACCUM, index=0, out_valid=0, out_data=0, out_last=0, in_ready=1 after deassertion.
REQ-030 Reset asserted mid-dump SHALL abort the readout immediately; no partial byte SHALL be presented after release.

Structure
REQ-031 A shared package product_acc_pkg SHALL hold the FSM state type, the ACC_W default and the BYTES=ACC_W/8 constant.
REQ-032 One sub-module, sat_adder (ACC_W-bit plus 8-bit saturating add with an overflow output), SHALL implement REQ-019.
REQ-033 Outputs SHALL be driven from registers or from state only; there SHALL be no combinational path from inputs to outputs other than in_ready from state.

Verification
REQ-034 Reset, accept products 225, 225, 100 -> acc=0x0226, count=3, overflow=0; then dump with out_ready=1 -> bytes 0x26, then 0x02 with out_last=1, then acc=0 and in_ready=1.
REQ-035 Preload acc=0xFFF0, accept 0x20 -> acc=0xFFFF and overflow=1; accept 0x01 -> acc still 0xFFFF and overflow still 1; acc_clear -> acc=0 and overflow=0.
REQ-036 Same-cycle accept of 0x10 and dump with acc=0x0005 -> readout bytes 0x15, 0x00.
REQ-037 During DUMP, hold out_ready=0 for 5 cycles -> out_data stable and in_ready=0; present in_valid=1 with 0x33 -> not accepted until the FSM returns to ACCUM.
REQ-038 Assert rst_n=0 after the first byte handshake -> out_valid=0 immediately, state=ACCUM, acc=0.
REQ-039 Accept 300 products -> count=255.
